// File: rtl/codec_ctrl_responder_if.sv
// Serial control link between the codec configurator (master) and the responder (slave).
// The slave treats cs, spi_sck and spi_mosi as asynchronous inputs.
interface codec_ctrl_responder_if;
    logic cs;
    logic spi_sck;
    logic spi_mosi;

    modport master (output cs, output spi_sck, output spi_mosi);
    modport slave  (input  cs, input  spi_sck, input  spi_mosi);
endinterface

// File: rtl/codec_ctrl_responder.sv
// In-fabric model of the codec 3-wire control port: shifts 16-bit words, decodes 7-bit
// address plus 9-bit data into a register file with power-on defaults, and reports writes.
module codec_ctrl_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 10,
    parameter logic [6:0] RESET_ADDR  = 7'h0F
) (
    input  logic                  clk,
    input  logic                  reset_n,
    codec_ctrl_responder_if.slave link,
    output logic                  wr_valid,
    output logic [6:0]            wr_addr,
    output logic [8:0]            wr_data,
    output logic                  soft_reset,
    output logic                  addr_err,
    output logic                  frame_err,
    input  logic [3:0]            rd_addr,
    output logic [8:0]            rd_data,
    output logic                  active,
    output logic [8:0]            pwr_down,
    output logic [6:0]            dai_fmt,
    output logic [6:0]            samp_ctrl
);

    localparam int         IDXW       = $clog2(NUM_REGS);
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_BOTH   = 2'd2
    } state_e;

    function automatic logic [8:0] reg_default(input int idx);
        logic [8:0] val;
        case (idx)
            0:       val = 9'h097;
            1:       val = 9'h097;
            2:       val = 9'h079;
            3:       val = 9'h079;
            4:       val = 9'h00A;
            5:       val = 9'h008;
            6:       val = 9'h09F;
            7:       val = 9'h00A;
            8:       val = 9'h000;
            9:       val = 9'h000;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_hist_q, sck_hist_q;
    logic                   cs_s, sck_s, mosi_s, cs_rise_s, sck_rise_s;

    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d, shift_nxt_s;
    logic [4:0]  bitcnt_q, bitcnt_d, cnt_nxt_s;
    logic [6:0]  word_addr_q, word_addr_d;
    logic [8:0]  word_data_q, word_data_d;
    logic [8:0]  regs_q [NUM_REGS];
    logic [8:0]  regs_d [NUM_REGS];
    logic        wr_valid_q, wr_valid_d;
    logic        soft_reset_q, soft_reset_d;
    logic        addr_err_q, addr_err_d;
    logic        frame_err_q, frame_err_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;
    logic [8:0]  rd_data_q, rd_data_d;
    logic [IDXW-1:0] idx_s, idx_nx_s;
    logic [6:0]  new_addr_s;

    // Input synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            cs_hist_q   <= 1'b1;
            sck_hist_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], link.cs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], link.spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], link.spi_mosi};
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
            sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise_s  = cs_s & ~cs_hist_q;
    assign sck_rise_s = sck_s & ~sck_hist_q;
    assign new_addr_s = shift_nxt_s[15:9];

    // Next-state logic: shifter, frame latch, commit FSM, register file and readback.
    always_comb begin
        shift_nxt_s = shift_q;
        cnt_nxt_s   = bitcnt_q;
        if (sck_rise_s) begin
            shift_nxt_s = {shift_q[14:0], mosi_s};
            cnt_nxt_s   = (bitcnt_q == 5'd31) ? 5'd31 : bitcnt_q + 5'd1;
        end else begin
            cnt_nxt_s   = bitcnt_q;
        end

        state_d      = state_q;
        shift_d      = shift_nxt_s;
        bitcnt_d     = cs_rise_s ? 5'd0 : cnt_nxt_s;
        word_addr_d  = word_addr_q;
        word_data_d  = word_data_q;
        regs_d       = regs_q;
        wr_valid_d   = 1'b0;
        soft_reset_d = 1'b0;
        addr_err_d   = 1'b0;
        frame_err_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        idx_s        = word_addr_q[IDXW-1:0];
        idx_nx_s     = idx_s + {{(IDXW-1){1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (cs_rise_s && (cnt_nxt_s >= 5'd16)) begin
                    word_addr_d = new_addr_s;
                    word_data_d = shift_nxt_s[8:0];
                    state_d     = ST_COMMIT;
                    // Write/error pulses are registered here so they line up with COMMIT.
                    if (new_addr_s < NUM_REGS_A) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = new_addr_s;
                        wr_data_d  = shift_nxt_s[8:0];
                    end else if (new_addr_s == RESET_ADDR) begin
                        wr_valid_d   = 1'b1;
                        soft_reset_d = 1'b1;
                        wr_addr_d    = RESET_ADDR;
                        wr_data_d    = shift_nxt_s[8:0];
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else if (cs_rise_s) begin
                    frame_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                frame_err_d = cs_rise_s;
                if (word_addr_q < NUM_REGS_A) begin
                    regs_d[idx_s] = word_data_q;
                end else if (word_addr_q == RESET_ADDR) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs_d[i] = reg_default(i);
                    end
                end else begin
                    regs_d = regs_q;
                end
                // LRINBOTH / LRHPBOTH mirror the write into the paired right-channel register.
                if (((word_addr_q == 7'h00) || (word_addr_q == 7'h02)) && word_data_q[8]) begin
                    state_d    = ST_BOTH;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = word_addr_q + 7'd1;
                    wr_data_d  = word_data_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOTH: begin
                frame_err_d      = cs_rise_s;
                regs_d[idx_nx_s] = word_data_q;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ({3'b000, rd_addr} < NUM_REGS_A) begin
            rd_data_d = regs_d[rd_addr];
        end else begin
            rd_data_d = 9'h000;
        end
    end

    // State, datapath and register-file flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= 16'h0000;
            bitcnt_q     <= 5'd0;
            word_addr_q  <= 7'h00;
            word_data_q  <= 9'h000;
            wr_valid_q   <= 1'b0;
            soft_reset_q <= 1'b0;
            addr_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_addr_q    <= 7'h00;
            wr_data_q    <= 9'h000;
            rd_data_q    <= 9'h000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reg_default(i);
            end
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            word_addr_q  <= word_addr_d;
            word_data_q  <= word_data_d;
            wr_valid_q   <= wr_valid_d;
            soft_reset_q <= soft_reset_d;
            addr_err_q   <= addr_err_d;
            frame_err_q  <= frame_err_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign soft_reset = soft_reset_q;
    assign addr_err   = addr_err_q;
    assign frame_err  = frame_err_q;
    assign rd_data    = rd_data_q;
    assign active     = regs_q[9][0];
    assign pwr_down   = regs_q[6];
    assign dai_fmt    = regs_q[7][6:0];
    assign samp_ctrl  = regs_q[8][6:0];

endmodule
